// File: rtl/lcd_frame_sequencer.sv
// lcd_frame_sequencer
//   Drives the command port of the LCD control IP as a two-line character
//   display. A 2 x NUM_COLS frame buffer is written by the host. The block
//   sends INIT once on i_start. Each frame it then sends SETCURSOR line 0,
//   NUM_COLS DATA, SETCURSOR line 1, and NUM_COLS DATA.
//
// Ports
//   i_clk, i_rst      clock, synchronous active-high reset
//   i_start           pulse: INIT followed by one frame (ignored while busy)
//   i_refresh         pulse: redraw the frame (ignored until initialised)
//   i_wr_en/addr/data frame buffer write port (addr 0..NUM_COLS-1 = line 0)
//   o_cmd_valid       command presented to the LCD control IP
//   o_cmd_func        function code (0 INIT, 1 SETCURSOR, 2 DATA)
//   o_cmd_data        character, or cursor {line[3:0], col[3:0]}
//   i_cmd_done        1-cycle pulse: current command finished
//   o_ready           INIT has completed since the last reset
//   o_busy            a command sequence is in progress
//   o_frame_done      1-cycle pulse after the last DATA of a frame
module lcd_frame_sequencer #(
  parameter int unsigned          SIZE_DATA  = 8,
  parameter int unsigned          SIZE_FUNC  = 2,
  parameter int unsigned          NUM_COLS   = 16,
  parameter logic [SIZE_DATA-1:0] BLANK_CHAR = SIZE_DATA'(8'h20)
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_start,
  input  logic                 i_refresh,
  input  logic                 i_wr_en,
  input  logic [4:0]           i_wr_addr,
  input  logic [SIZE_DATA-1:0] i_wr_data,
  output logic                 o_cmd_valid,
  output logic [SIZE_FUNC-1:0] o_cmd_func,
  output logic [SIZE_DATA-1:0] o_cmd_data,
  input  logic                 i_cmd_done,
  output logic                 o_ready,
  output logic                 o_busy,
  output logic                 o_frame_done
);

  localparam int unsigned DEPTH     = 2 * NUM_COLS;
  localparam int unsigned AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned LAST_STEP = 2 * NUM_COLS + 2;
  localparam int unsigned SW        = $clog2(LAST_STEP + 1);

  localparam logic [SIZE_FUNC-1:0] FUNC_INIT   = SIZE_FUNC'(0);
  localparam logic [SIZE_FUNC-1:0] FUNC_SETCUR = SIZE_FUNC'(1);
  localparam logic [SIZE_FUNC-1:0] FUNC_DATA   = SIZE_FUNC'(2);

  localparam logic [SIZE_DATA-1:0] CURSOR_L0 = SIZE_DATA'(8'h00);
  localparam logic [SIZE_DATA-1:0] CURSOR_L1 = SIZE_DATA'(8'h10);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_GAP,
    S_DONE
  } state_t;

  state_t               r_state;
  logic [SW-1:0]        r_step;
  logic                 r_dirty;
  logic                 r_cmd_valid;
  logic [SIZE_FUNC-1:0] r_cmd_func;
  logic [SIZE_DATA-1:0] r_cmd_data;
  logic                 r_ready;
  logic                 r_busy;
  logic                 r_frame_done;
  logic [SIZE_DATA-1:0] r_buf [DEPTH];

  logic                 w_wr_in_range;
  logic [SIZE_FUNC-1:0] w_func;
  logic [SIZE_DATA-1:0] w_data;
  logic [AW-1:0]        w_idx;

  assign w_wr_in_range = (32'(i_wr_addr) < DEPTH);

  // Decode the step pointer into the command to issue. Line 1 data sits one
  // step later than its buffer index because of the second SETCURSOR.
  always_comb begin
    w_func = FUNC_DATA;
    w_data = '0;
    w_idx  = '0;
    if (r_step == '0) begin
      w_func = FUNC_INIT;
    end else if (r_step == SW'(1)) begin
      w_func = FUNC_SETCUR;
      w_data = CURSOR_L0;
    end else if (r_step == SW'(NUM_COLS + 2)) begin
      w_func = FUNC_SETCUR;
      w_data = CURSOR_L1;
    end else if (r_step <= SW'(NUM_COLS + 1)) begin
      w_idx = AW'(r_step - SW'(2));
    end else begin
      w_idx = AW'(r_step - SW'(3));
    end
    if (w_func == FUNC_DATA) begin
      w_data = r_buf[w_idx];
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= S_IDLE;
      r_step       <= '0;
      r_dirty      <= 1'b0;
      r_cmd_valid  <= 1'b0;
      r_cmd_func   <= '0;
      r_cmd_data   <= '0;
      r_ready      <= 1'b0;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_buf[i] <= BLANK_CHAR;
      end
    end else begin
      r_frame_done <= 1'b0;

      if (i_wr_en && w_wr_in_range) begin
        r_buf[i_wr_addr[AW-1:0]] <= i_wr_data;
      end

      // Content changes or redraw requests after init are remembered. The
      // flag is cleared when the first SETCURSOR of a frame starts. All buffer
      // reads happen after that point, so the clear below may take priority.
      if ((i_wr_en || i_refresh) && r_ready) begin
        r_dirty <= 1'b1;
      end

      case (r_state)
        S_IDLE: begin
          if (i_start && !r_busy) begin
            r_step  <= '0;
            r_busy  <= 1'b1;
            r_state <= S_ISSUE;
          end else if ((i_refresh || r_dirty) && r_ready) begin
            r_step  <= SW'(1);
            r_dirty <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= S_ISSUE;
          end
        end

        S_ISSUE: begin
          r_cmd_func  <= w_func;
          r_cmd_data  <= w_data;
          r_cmd_valid <= 1'b1;
          r_state     <= S_WAIT;
        end

        S_WAIT: begin
          if (i_cmd_done) begin
            r_cmd_valid <= 1'b0;
            if (r_step == '0) begin
              r_ready <= 1'b1;
              r_dirty <= 1'b0;
            end
            if (r_step == SW'(LAST_STEP)) begin
              r_frame_done <= 1'b1;
              r_state      <= S_DONE;
            end else begin
              r_step  <= r_step + SW'(1);
              r_state <= S_GAP;
            end
          end
        end

        S_GAP: begin
          r_state <= S_ISSUE;
        end

        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_cmd_valid  = r_cmd_valid;
  assign o_cmd_func   = r_cmd_func;
  assign o_cmd_data   = r_cmd_data;
  assign o_ready      = r_ready;
  assign o_busy       = r_busy;
  assign o_frame_done = r_frame_done;

endmodule

// File: tb/tb_lcd_frame_sequencer.sv
// Scoreboard bench for lcd_frame_sequencer. The stimulus keeps a model of the
// frame buffer and pushes the expected command stream into a queue. A monitor
// pops one entry each time o_cmd_valid rises and compares it with the DUT.
module tb_lcd_frame_sequencer;

  logic       clk;
  logic       i_rst;
  logic       i_start;
  logic       i_refresh;
  logic       i_wr_en;
  logic [4:0] i_wr_addr;
  logic [7:0] i_wr_data;
  logic       o_cmd_valid;
  logic [1:0] o_cmd_func;
  logic [7:0] o_cmd_data;
  logic       i_cmd_done;
  logic       o_ready;
  logic       o_busy;
  logic       o_frame_done;

  lcd_frame_sequencer #(
    .SIZE_DATA (8),
    .SIZE_FUNC (2),
    .NUM_COLS  (16),
    .BLANK_CHAR(8'h20)
  ) dut (
    .i_clk       (clk),
    .i_rst       (i_rst),
    .i_start     (i_start),
    .i_refresh   (i_refresh),
    .i_wr_en     (i_wr_en),
    .i_wr_addr   (i_wr_addr),
    .i_wr_data   (i_wr_data),
    .o_cmd_valid (o_cmd_valid),
    .o_cmd_func  (o_cmd_func),
    .o_cmd_data  (o_cmd_data),
    .i_cmd_done  (i_cmd_done),
    .o_ready     (o_ready),
    .o_busy      (o_busy),
    .o_frame_done(o_frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] func;
    logic [7:0] data;
    bit         last;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] mbuf [32];
  int         checks      = 0;
  int         failures    = 0;
  int         n_cmds      = 0;
  int         n_fd        = 0;
  int         n_frames_exp = 0;
  bit         hold_done   = 1'b0;
  int         resp_fixed  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Reference: a frame is SETCURSOR line 0, line 0 text, SETCURSOR line 1,
  // line 1 text, taken from the model buffer as it is when the frame is queued.
  task automatic push_cmd(input logic [1:0] f, input logic [7:0] d, input bit last);
    exp_t e;
    e.func = f;
    e.data = d;
    e.last = last;
    exp_q.push_back(e);
  endtask

  task automatic push_init();
    push_cmd(2'd0, 8'h00, 1'b0);
  endtask

  task automatic push_frame();
    push_cmd(2'd1, 8'h00, 1'b0);
    for (int c = 0; c < 16; c++) push_cmd(2'd2, mbuf[c], 1'b0);
    push_cmd(2'd1, 8'h10, 1'b0);
    for (int c = 0; c < 16; c++) push_cmd(2'd2, mbuf[16 + c], c == 15);
    n_frames_exp++;
  endtask

  task automatic blank_model();
    for (int a = 0; a < 32; a++) mbuf[a] = 8'h20;
  endtask

  task automatic pulse(input bit s, input bit r);
    @(negedge clk);
    i_start   = s;
    i_refresh = r;
    @(negedge clk);
    i_start   = 1'b0;
    i_refresh = 1'b0;
  endtask

  task automatic wr(input logic [4:0] a, input logic [7:0] d);
    @(negedge clk);
    i_wr_en   = 1'b1;
    i_wr_addr = a;
    i_wr_data = d;
    mbuf[a]   = d;
    @(negedge clk);
    i_wr_en   = 1'b0;
  endtask

  task automatic wait_frames(input int target, input string name);
    for (int k = 0; k < 20000 && n_fd < target; k++) @(negedge clk);
    chk(name, n_fd, target);
  endtask

  task automatic wait_cmds(input int target, input string name);
    for (int k = 0; k < 20000 && n_cmds < target; k++) @(negedge clk);
    if (n_cmds < target) chk(name, n_cmds, target);
  endtask

  // No further frames may start once the queued work is done.
  task automatic settle(input string name);
    repeat (300) @(negedge clk);
    chk({name, "_frames"}, n_fd, n_frames_exp);
    chk({name, "_queue_empty"}, exp_q.size(), 0);
    chk({name, "_idle"}, o_busy, 1'b0);
  endtask

  // Responder: answers each command after a delay of 1..4 cycles, or a fixed delay.
  initial begin
    int d;
    i_cmd_done = 1'b0;
    forever begin
      @(negedge clk);
      if (o_cmd_valid && !hold_done && !i_rst) begin
        d = (resp_fixed != 0) ? resp_fixed : int'($urandom_range(1, 4));
        repeat (d - 1) @(negedge clk);
        i_cmd_done = 1'b1;
        @(negedge clk);
        i_cmd_done = 1'b0;
      end
    end
  end

  // Monitor / scoreboard checker.
  initial begin
    logic       prev_valid = 1'b0;
    logic       prev_fd    = 1'b0;
    logic [1:0] prev_func  = '0;
    logic [7:0] prev_data  = '0;
    bit         unstable   = 1'b0;
    bit         last_was_end = 1'b0;
    exp_t       e;
    forever begin
      @(negedge clk);
      if (o_cmd_valid && !prev_valid) begin
        n_cmds++;
        chk("busy_during_cmd", o_busy, 1'b1);
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_cmd actual=%0h_%0h required=none", o_cmd_func, o_cmd_data);
          last_was_end = 1'b0;
        end else begin
          e = exp_q.pop_front();
          chk("cmd_func_data", {o_cmd_func, o_cmd_data}, {e.func, e.data});
          last_was_end = e.last;
        end
      end else if (o_cmd_valid && prev_valid) begin
        if (o_cmd_func !== prev_func || o_cmd_data !== prev_data) unstable = 1'b1;
      end else if (!o_cmd_valid && prev_valid) begin
        chk("cmd_stable", unstable, 1'b0);
        unstable = 1'b0;
      end
      if (o_frame_done) begin
        n_fd++;
        chk("frame_done_after_last_data", last_was_end, 1'b1);
        chk("frame_done_one_cycle", prev_fd, 1'b0);
        last_was_end = 1'b0;
      end
      prev_valid = o_cmd_valid;
      prev_fd    = o_frame_done;
      prev_func  = o_cmd_func;
      prev_data  = o_cmd_data;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit         any_out;
    int         base;
    int         kind;
    logic [4:0] a;
    logic [7:0] d;

    i_rst = 1'b1; i_start = 1'b0; i_refresh = 1'b0;
    i_wr_en = 1'b0; i_wr_addr = '0; i_wr_data = '0;
    blank_model();
    repeat (5) @(negedge clk);
    i_rst = 1'b0;

    // Reset state and silence without stimulus.
    chk("rst_valid", o_cmd_valid, 1'b0);
    chk("rst_func", o_cmd_func, 2'd0);
    chk("rst_data", o_cmd_data, 8'h00);
    chk("rst_ready", o_ready, 1'b0);
    chk("rst_busy", o_busy, 1'b0);
    chk("rst_frame_done", o_frame_done, 1'b0);
    any_out = 1'b0;
    repeat (100) begin
      @(negedge clk);
      if (o_cmd_valid || o_busy || o_ready || o_frame_done) any_out = 1'b1;
    end
    chk("quiet_after_reset", any_out, 1'b0);

    // Refresh before init is ignored.
    pulse(1'b0, 1'b1);
    repeat (50) @(negedge clk);
    chk("refresh_before_ready_cmds", n_cmds, 0);
    chk("refresh_before_ready_busy", o_busy, 1'b0);

    // Start with a fixed 3-cycle responder: INIT plus a blank frame.
    resp_fixed = 3;
    push_init();
    push_frame();
    pulse(1'b1, 1'b0);
    wait_frames(1, "start_frame_done");
    chk("ready_after_init", o_ready, 1'b1);
    chk("start_cmd_count", n_cmds, 35);
    settle("start");
    resp_fixed = 0;

    // Stall the responder on INIT, then reset mid-sequence.
    hold_done = 1'b1;
    push_init();
    pulse(1'b1, 1'b0);
    repeat (10000) @(negedge clk);
    chk("stall_valid", o_cmd_valid, 1'b1);
    chk("stall_func_data", {o_cmd_func, o_cmd_data}, {2'd0, 8'h00});
    chk("stall_queue", exp_q.size(), 0);
    i_rst = 1'b1;
    @(posedge clk);
    #1;
    chk("midreset_valid", o_cmd_valid, 1'b0);
    chk("midreset_ready", o_ready, 1'b0);
    @(negedge clk);
    i_rst = 1'b0;
    hold_done = 1'b0;
    exp_q.delete();
    blank_model();

    // Pre-init writes land in the buffer and show in the first frame.
    wr(5'd5, 8'h41);
    wr(5'd16, 8'h42);
    repeat (4) begin
      a = 5'($urandom_range(0, 31));
      if (a != 5'd5 && a != 5'd16) wr(a, 8'($urandom_range(8'h21, 8'h7e)));
    end
    repeat (20) @(negedge clk);
    chk("prewrite_no_cmd", o_busy, 1'b0);
    push_init();
    push_frame();
    pulse(1'b1, 1'b0);
    wait_frames(n_frames_exp, "prewrite_frame_done");
    chk("ready_after_reinit", o_ready, 1'b1);
    settle("prewrite");

    // Start and refresh together when ready: INIT first, then a single frame.
    push_init();
    push_frame();
    pulse(1'b1, 1'b1);
    wait_frames(n_frames_exp, "start_refresh_frame_done");
    settle("start_refresh");

    // A line 0 write mid-frame, after line 0 has been sent, gives one more frame.
    base = n_cmds;
    push_frame();
    pulse(1'b0, 1'b1);
    wait_cmds(base + 18, "midframe_wait_cmds");
    chk("midframe_busy", o_busy, 1'b1);
    wr(5'd0, 8'h5A);
    push_frame();
    wait_frames(n_frames_exp, "midframe_frame_done");
    settle("midframe");

    // Random rounds.
    for (int r = 0; r < 12; r++) begin
      kind = int'($urandom_range(0, 3));
      case (kind)
        0: begin
          a = 5'($urandom_range(0, 31));
          d = 8'($urandom);
          wr(a, d);
          push_frame();
        end
        1: begin
          push_frame();
          pulse(1'b0, 1'b1);
        end
        2: begin
          push_init();
          push_frame();
          pulse(1'b1, 1'($urandom_range(0, 1)));
        end
        default: begin
          base = n_cmds;
          push_frame();
          pulse(1'b0, 1'b1);
          wait_cmds(base + 18, "rand_mid_wait_cmds");
          if ($urandom_range(0, 1) == 1) begin
            wr(5'($urandom_range(0, 15)), 8'($urandom));
          end else begin
            pulse(1'b0, 1'b1);
          end
          push_frame();
        end
      endcase
      wait_frames(n_frames_exp, "rand_frame_done");
      settle("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
